// File: rtl/mul_unit_pkg.sv
// Shared definitions for the iterative shift-add multiplier.
package mul_unit_pkg;

  localparam int unsigned MUL_WIDTH = 32;
  localparam int unsigned MUL_ITER  = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_ITER = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } mul_state_t;

endpackage

// File: rtl/mul_unit_if.sv
// Start/busy/done handshake and operand/result bus between execute control and mul_unit.
interface mul_unit_if;
  import mul_unit_pkg::*;

  logic                 start;
  logic                 is_signed;
  logic [MUL_WIDTH-1:0] op_a;
  logic [MUL_WIDTH-1:0] op_b;
  logic                 busy;
  logic                 done;
  logic [MUL_WIDTH-1:0] hi;
  logic [MUL_WIDTH-1:0] lo;

  modport master (
    output start, is_signed, op_a, op_b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, is_signed, op_a, op_b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/cla32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups, group carries chained.
module cla32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_sum,
  output logic        o_cout
);
  logic [31:0] w_g;
  logic [31:0] w_p;
  logic [32:0] w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Per-group lookahead carries, each group fed by the previous group's carry-out
  always_comb begin
    int unsigned b;
    logic        c0;
    w_c    = '0;
    w_c[0] = i_cin;
    for (int unsigned j = 0; j < 8; j++) begin
      b  = 4 * j;
      c0 = w_c[b];
      w_c[b+1] = w_g[b] | (w_p[b] & c0);
      w_c[b+2] = w_g[b+1] | (w_p[b+1] & w_g[b]) | (w_p[b+1] & w_p[b] & c0);
      w_c[b+3] = w_g[b+2] | (w_p[b+2] & w_g[b+1]) | (w_p[b+2] & w_p[b+1] & w_g[b])
               | (w_p[b+2] & w_p[b+1] & w_p[b] & c0);
      w_c[b+4] = w_g[b+3] | (w_p[b+3] & w_g[b+2]) | (w_p[b+3] & w_p[b+2] & w_g[b+1])
               | (w_p[b+3] & w_p[b+2] & w_p[b+1] & w_g[b])
               | (w_p[b+3] & w_p[b+2] & w_p[b+1] & w_p[b] & c0);
    end
  end

  assign o_sum  = w_p ^ w_c[31:0];
  assign o_cout = w_c[32];
endmodule

// File: rtl/mul_negate64.sv
// Two's-complement negate built from two chained CLA32 adds.
// i_split=1 cuts the carry between halves, giving two independent 32-bit negates.
module mul_negate64 (
  input  logic [63:0] i_val,
  input  logic        i_split,
  output logic [63:0] o_neg
);
  logic w_lo_cout;
  logic w_hi_cin;
  logic w_cout_unused;

  assign w_hi_cin = i_split ? 1'b1 : w_lo_cout;

  cla32 u_lo (
    .i_a    (~i_val[31:0]),
    .i_b    ('0),
    .i_cin  (1'b1),
    .o_sum  (o_neg[31:0]),
    .o_cout (w_lo_cout)
  );

  cla32 u_hi (
    .i_a    (~i_val[63:32]),
    .i_b    ('0),
    .i_cin  (w_hi_cin),
    .o_sum  (o_neg[63:32]),
    .o_cout (w_cout_unused)
  );
endmodule

// File: rtl/mul_unit.sv
// Iterative 32x32->64 shift-add multiplier (MULT/MULTU), fixed 34-cycle latency.
module mul_unit
  import mul_unit_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH,
  parameter int unsigned ITER  = MUL_ITER
) (
  input  logic       clk,
  input  logic       rst,
  mul_unit_if.slave  bus
);
  mul_state_t           r_state;
  logic                 r_busy;
  logic                 r_done;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic                 r_signed;
  logic                 r_neg;
  logic [2*WIDTH:0]     r_acc;
  logic [5:0]           r_cnt;

  logic [WIDTH-1:0]     w_sum;
  logic                 w_cout;
  logic                 w_split;
  logic [2*WIDTH-1:0]   w_neg_in;
  logic [2*WIDTH-1:0]   w_neg_out;
  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic [2*WIDTH:0]     w_acc_add;
  logic [2*WIDTH:0]     w_acc_next;

  // One negate unit shared: split 32-bit magnitudes in PREP, full 64-bit sign fix in FIX
  always_comb begin
    w_split  = (r_state != ST_FIX);
    w_neg_in = w_split ? {r_b, r_a} : r_acc[2*WIDTH-1:0];
    w_mag_a  = (r_signed & r_a[WIDTH-1]) ? w_neg_out[WIDTH-1:0]       : r_a;
    w_mag_b  = (r_signed & r_b[WIDTH-1]) ? w_neg_out[2*WIDTH-1:WIDTH] : r_b;
  end

  mul_negate64 u_neg (
    .i_val   (w_neg_in),
    .i_split (w_split),
    .o_neg   (w_neg_out)
  );

  cla32 u_add (
    .i_a    (r_acc[2*WIDTH-1:WIDTH]),
    .i_b    (r_a),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // One shift-add step: conditional add of |a| into the upper half, then shift right
  always_comb begin
    w_acc_add  = r_acc[0] ? {w_cout, w_sum, r_acc[WIDTH-1:0]} : r_acc;
    w_acc_next = w_acc_add >> 1;
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_neg    <= 1'b0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_a      <= bus.op_a;
            r_b      <= bus.op_b;
            r_signed <= bus.is_signed;
            r_busy   <= 1'b1;
            r_state  <= ST_PREP;
          end else begin
            r_state  <= ST_IDLE;
          end
        end
        ST_PREP: begin
          r_a     <= w_mag_a;
          r_neg   <= r_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
          r_acc   <= {{(WIDTH+1){1'b0}}, w_mag_b};
          r_cnt   <= '0;
          r_state <= ST_ITER;
        end
        ST_ITER: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'(ITER - 1)) begin
            r_state <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (r_neg) begin
            {r_hi, r_lo} <= w_neg_out;
          end else begin
            {r_hi, r_lo} <= r_acc[2*WIDTH-1:0];
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= ST_DONE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
endmodule

// File: doc/mul_unit.md
Name: mul_unit

Overview:
- Iterative 32x32 -> 64-bit shift-add multiplier for the CPU's MULT/MULTU instructions.
- Sits directly upstream of the HI/LO registers and consumes the 32-bit carry-lookahead adder (CLA32): one partial-product add per cycle.
- Start/busy/done handshake toward the execute-stage control; a fixed 34-cycle latency lets the pipeline stall deterministically.

Parameters:
- WIDTH, 32, operand width; the result is 2*WIDTH. Only 32 is supported, because the adder is fixed at 32 bits.
- ITER, 32, number of shift-add iterations; must equal WIDTH.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only when busy=0.
- is_signed  input  1  1 = MULT (two's complement), 0 = MULTU; captured with start.
- op_a  input  32  multiplicand; captured with start.
- op_b  input  32  multiplier; captured with start.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse; hi/lo are valid from this cycle onward.
- hi  output  32  product bits [63:32], registered.
- lo  output  32  product bits [31:0], registered.

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE; busy=0, done=0, hi=0, lo=0; internal accumulator and counter are cleared. This applies in any state, including mid-operation; the aborted operation never raises done.
- States and transitions:
  - IDLE -> PREP on start=1. Latch op_a, op_b, is_signed.
  - PREP (1 cycle):
    - If is_signed, replace each operand by its magnitude (negate when bit31=1).
    - Record neg = is_signed & (a31 ^ b31).
    - Load acc[64:0] = {33'b0, |b|}; clear the 6-bit counter.
  - ITER (32 cycles):
    - If acc[0]=1, acc[64:32] = CLA32(acc[63:32], |a|, Cin=0) with Cout into bit 64; otherwise acc[64:32] is unchanged.
    - Then acc = acc >> 1.
    - Counter increments; after the 32nd iteration -> FIX.
  - FIX (1 cycle):
    - If neg, product = ~acc[63:0] + 1 (two chained 32-bit adds, low Cout feeding high Cin); otherwise product = acc[63:0].
    - Load hi/lo -> DONE.
  - DONE (1 cycle): done=1, busy=0. -> IDLE, or -> PREP if start=1 in this cycle.
- busy=1 exactly in PREP, ITER and FIX.
- Latency: start sampled at edge k; done high during the cycle after edge k+34, so 34 cycles of busy.
- Throughput: one operation per 35 cycles when start is held high continuously.
- start while busy=1 is ignored; inputs are not re-latched.
- hi/lo hold their last result until the next FIX or reset; they do not change during a following operation.
- Magnitude of 0x80000000 is 0x80000000 (it fits unsigned 32 bits); no overflow special case is needed.
- Signed products never need a 65th bit; for unsigned, acc[64] carries the intermediate add carry and is shifted down before the next add.
- Operand of zero: still takes the full 34 cycles; the result is 0 and neg is irrelevant (negating 0 gives 0).
- X on op_a/op_b/is_signed when start=0 must not propagate to hi/lo.

Decomposition:
- Shared package/header: state encoding constants (IDLE, PREP, ITER, FIX, DONE; 3-bit), MUL_WIDTH=32, MUL_ITER=32.
- Sub-modules: reuse the existing CLA32 for the iteration add. One natural new sub-module, mul_negate64, performs the two's-complement negate for PREP (32-bit use) and FIX (64-bit use) using CLA32 instances.

Test Plan:
- Unsigned: start, is_signed=0, op_a=3, op_b=5 -> done exactly 34 cycles after start edge; hi=0x00000000, lo=0x0000000F.
- Unsigned max: op_a=op_b=0xFFFFFFFF, is_signed=0 -> hi=0xFFFFFFFE, lo=0x00000001.
- Signed mixed sign: op_a=7, op_b=0xFFFFFFFD (-3), is_signed=1 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Also op_a=0xFFFFFFFF, op_b=1 -> hi=lo=0xFFFFFFFF.
- Signed corner: op_a=op_b=0x80000000, is_signed=1 -> hi=0x40000000, lo=0x00000000. Same operands with is_signed=0 -> hi=0x40000000, lo=0x00000000.
- Start while busy: second start with different operands at cycle 5 -> ignored; the first result is delivered unchanged, and done pulses exactly once.
- Reset mid-operation: assert rst at cycle 10 of a busy operation -> next cycle busy=0, done=0, hi=lo=0, and no done pulse ever appears for that operation. A new start of 6*7 then yields lo=42 after 34 cycles.
